// File: rtl/memory_array.sv
// memory_array: parametrised memory with one write port, one read port and a hardware clear sequencer.
// Optional build macro MEMORY_READ_REG_EN selects a registered, write-first read port.
module memory_array #(
  parameter int                    DATA_WIDTH  = 8,
  parameter int                    DEPTH       = 16,
  parameter int                    ADDR_WIDTH  = $clog2(DEPTH),
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = {DATA_WIDTH{1'b0}}
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  write_enable,
  input  logic [ADDR_WIDTH-1:0] write_address,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [ADDR_WIDTH-1:0] read_address,
  output logic [DATA_WIDTH-1:0] data_out,
  input  logic                  clear_start,
  output logic                  busy,
  output logic                  clear_done
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [ADDR_WIDTH:0]   DEPTH_EXT = (ADDR_WIDTH + 1)'(DEPTH);

  typedef enum logic [1:0] {CLEAR, DONE, IDLE} state_t;

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] ptr, ptr_nxt;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_wa;
  logic [DATA_WIDTH-1:0] mem_wd;
  logic                  wr_in_range, rd_in_range;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // DEPTH need not be a power of two, so addresses are range-checked one bit wider
  assign wr_in_range = {1'b0, write_address} < DEPTH_EXT;
  assign rd_in_range = {1'b0, read_address}  < DEPTH_EXT;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= CLEAR;
      ptr   <= '0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    ptr_nxt    = ptr;
    busy       = 1'b0;
    clear_done = 1'b0;
    mem_we     = 1'b0;
    mem_wa     = write_address;
    mem_wd     = data_in;
    unique case (state)
      CLEAR: begin
        busy   = 1'b1;
        mem_we = 1'b1;
        mem_wa = ptr;
        mem_wd = CLEAR_VALUE;
        if (ptr == LAST_ADDR) begin
          state_nxt = DONE;
          ptr_nxt   = '0;
        end else begin
          ptr_nxt = ptr + ADDR_WIDTH'(1);
        end
      end
      DONE: begin
        clear_done = 1'b1;
        mem_we     = write_enable && wr_in_range;
        state_nxt  = IDLE;
      end
      IDLE: begin
        // a simultaneous write still lands; the sweep overwrites it later
        mem_we = write_enable && wr_in_range;
        if (clear_start) begin
          state_nxt = CLEAR;
          ptr_nxt   = '0;
        end
      end
      default: begin
        state_nxt = CLEAR;
        ptr_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_wa] <= mem_wd;
  end

`ifdef MEMORY_READ_REG_EN
  logic [DATA_WIDTH-1:0] rd_data_p1;

  // read stage: write-first bypass so a same-address write is seen after the edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                         rd_data_p1 <= '0;
    else if (busy)                                      rd_data_p1 <= CLEAR_VALUE;
    else if (!rd_in_range)                              rd_data_p1 <= '0;
    else if (mem_we && (write_address == read_address)) rd_data_p1 <= data_in;
    else                                                rd_data_p1 <= mem[read_address];
  end

  assign data_out = rd_data_p1;
`else
  always_comb begin
    data_out = '0;
    if (busy)             data_out = CLEAR_VALUE;
    else if (rd_in_range) data_out = mem[read_address];
  end
`endif

endmodule

// File: tb/tb_memory_array.sv
// Self-checking bench for memory_array: vector table, directed sweep/reset sequences and a
// randomized phase against an array model, on a DEPTH=16 and a DEPTH=10 instance.
module tb_memory_array;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, we, cs;
  logic [3:0] wa, ra;
  logic [7:0] din, dout;
  logic       busy, cdone;

  logic       rst10_n, we10, cs10;
  logic [3:0] wa10, ra10;
  logic [7:0] din10, dout10;
  logic       busy10, cdone10;

  int tests_run = 0;
  int tests_failed = 0;

  logic [7:0] m16 [16];
  logic [7:0] m10 [10];

  memory_array #(.DATA_WIDTH(8), .DEPTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .write_enable(we), .write_address(wa), .data_in(din),
    .read_address(ra), .data_out(dout), .clear_start(cs), .busy(busy), .clear_done(cdone)
  );

  memory_array #(.DATA_WIDTH(8), .DEPTH(10), .CLEAR_VALUE(8'hC3)) dut10 (
    .clk(clk), .rst_n(rst10_n), .write_enable(we10), .write_address(wa10), .data_in(din10),
    .read_address(ra10), .data_out(dout10), .clear_start(cs10), .busy(busy10), .clear_done(cdone10)
  );

  typedef struct {
    logic       we;
    logic [3:0] wa;
    logic [7:0] din;
    logic [3:0] ra;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Steps until clear_done (bounded) and checks edge count, busy and data_out during the sweep.
  task automatic run_sweep(input string tag, input int exp_edges, input bit is16);
    int   edges = 0;
    bit   busy_ok = 1'b1;
    bit   dout_ok = 1'b1;
    logic [7:0] cv = is16 ? 8'h00 : 8'hC3;
    while (!(is16 ? cdone : cdone10) && edges < 64) begin
      step();
      edges++;
      if (!(is16 ? cdone : cdone10)) begin
        if (!(is16 ? busy : busy10)) busy_ok = 1'b0;
        if (edges >= 2 && (is16 ? dout : dout10) !== cv) dout_ok = 1'b0;
      end
    end
    check({tag, " edges to clear_done"}, edges, exp_edges);
    check({tag, " busy held during sweep"}, {31'd0, busy_ok}, 1);
    check({tag, " data_out is CLEAR_VALUE while busy"}, {31'd0, dout_ok}, 1);
    check({tag, " busy low with clear_done"}, {31'd0, is16 ? busy : busy10}, 0);
    step();
    check({tag, " clear_done one cycle"}, {31'd0, is16 ? cdone : cdone10}, 0);
  endtask

  task automatic read_all16(input string tag);
    we = 1'b0;
    for (int i = 0; i < 16; i++) begin
      ra = 4'(i);
      step();
      check($sformatf("%s rd16[%0d]", tag, i), {24'd0, dout}, {24'd0, m16[i]});
    end
  endtask

  task automatic read_all10(input string tag);
    we10 = 1'b0;
    for (int i = 0; i < 16; i++) begin
      ra10 = 4'(i);
      step();
      check($sformatf("%s rd10[%0d]", tag, i), {24'd0, dout10}, {24'd0, (i < 10) ? m10[i] : 8'h00});
    end
  endtask

  task automatic fill16(input logic [7:0] base);
    for (int i = 0; i < 16; i++) begin
      we = 1'b1; wa = 4'(i); din = base + 8'(i);
      step();
      m16[i] = din;
    end
    we = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; we = 1'b0; cs = 1'b0; wa = '0; ra = '0; din = '0;
    rst10_n = 1'b0; we10 = 1'b0; cs10 = 1'b0; wa10 = '0; ra10 = '0; din10 = '0;
    for (int i = 0; i < 16; i++) m16[i] = 8'h00;
    for (int i = 0; i < 10; i++) m10[i] = 8'hC3;

    vecs[0] = '{1'b1, 4'd3,  8'hA5, 4'd3,  8'hA5};
    vecs[1] = '{1'b1, 4'd15, 8'h5A, 4'd15, 8'h5A};
    vecs[2] = '{1'b0, 4'd0,  8'h00, 4'd3,  8'hA5};
    vecs[3] = '{1'b0, 4'd0,  8'h00, 4'd15, 8'h5A};
    vecs[4] = '{1'b0, 4'd0,  8'h00, 4'd0,  8'h00};
    vecs[5] = '{1'b0, 4'd0,  8'h00, 4'd7,  8'h00};
    vecs[6] = '{1'b0, 4'd0,  8'h00, 4'd14, 8'h00};
    vecs[7] = '{1'b1, 4'd3,  8'hC3, 4'd15, 8'h5A};
    vecs[8] = '{1'b0, 4'd0,  8'h00, 4'd3,  8'hC3};
    vecs[9] = '{1'b1, 4'd15, 8'h00, 4'd15, 8'h00};

    #12;
    check("reset busy16", {31'd0, busy}, 1);
    check("reset clear_done16", {31'd0, cdone}, 0);
    check("reset data_out16", {24'd0, dout}, 0);
    check("reset busy10", {31'd0, busy10}, 1);

    // Power-up sweep of the DEPTH=16 instance
    @(negedge clk);
    rst_n = 1'b1;
    run_sweep("init16", 16, 1'b1);
    read_all16("init16");

    // Power-up sweep of the DEPTH=10 instance, then out-of-range writes
    @(negedge clk);
    rst10_n = 1'b1;
    run_sweep("init10", 10, 1'b0);
    read_all10("init10");
    we10 = 1'b1; wa10 = 4'd3; din10 = 8'h44; step(); m10[3] = 8'h44;
    we10 = 1'b1; wa10 = 4'd12; din10 = 8'hFF; ra10 = 4'd12; step();
    check("oor write readback", {24'd0, dout10}, 0);
    we10 = 1'b0;
    read_all10("oor10");

    // Vector table on the DEPTH=16 instance
    for (int i = 0; i < 10; i++) begin
      we = vecs[i].we; wa = vecs[i].wa; din = vecs[i].din; ra = vecs[i].ra;
      step();
      check($sformatf("vec[%0d]", i), {24'd0, dout}, {24'd0, vecs[i].exp});
      if (vecs[i].we) m16[vecs[i].wa] = vecs[i].din;
    end
    we = 1'b0;

    // Same-address write/read and read latency
    we = 1'b1; wa = 4'd4; din = 8'h3C; ra = 4'd4;
    step();
    m16[4] = 8'h3C;
    check("wr-first addr4", {24'd0, dout}, 8'h3C);
    we = 1'b0; ra = 4'd5;
`ifdef MEMORY_READ_REG_EN
    #1;
    check("reg read holds old", {24'd0, dout}, 8'h3C);
    step();
    check("reg read addr5", {24'd0, dout}, {24'd0, m16[5]});
    ra = 4'd4;
    #1;
    check("reg read addr4 pending", {24'd0, dout}, {24'd0, m16[5]});
    step();
    check("reg read addr4", {24'd0, dout}, 8'h3C);
`else
    #1;
    check("comb read addr5", {24'd0, dout}, {24'd0, m16[5]});
    ra = 4'd4;
    #1;
    check("comb read addr4", {24'd0, dout}, 8'h3C);
`endif

    // Randomized traffic on both instances against the array model
    for (int n = 0; n < 300; n++) begin
      we = 1'($urandom_range(1)); wa = 4'($urandom_range(15)); din = 8'($urandom);
      ra = ($urandom_range(1) == 1) ? wa : 4'($urandom_range(15));
      we10 = 1'($urandom_range(1)); wa10 = 4'($urandom_range(15)); din10 = 8'($urandom);
      ra10 = ($urandom_range(1) == 1) ? wa10 : 4'($urandom_range(15));
      step();
      if (we) m16[wa] = din;
      if (we10 && wa10 < 4'd10) m10[wa10] = din10;
      check($sformatf("rand16[%0d]", n), {24'd0, dout}, {24'd0, m16[ra]});
      check($sformatf("rand10[%0d]", n), {24'd0, dout10},
            {24'd0, (ra10 < 4'd10) ? m10[ra10] : 8'h00});
    end
    we = 1'b0; we10 = 1'b0;

    // Writes attempted during a sweep are ignored
    fill16(8'h20);
    cs = 1'b1;
    step();
    cs = 1'b0;
    check("cs to busy", {31'd0, busy}, 1);
    we = 1'b1; wa = 4'd2; din = 8'h11; ra = 4'd9;
    for (int i = 0; i < 14; i++) step();
    we = 1'b0;
    run_sweep("wr-during-sweep", 2, 1'b1);
    for (int i = 0; i < 16; i++) m16[i] = 8'h00;
    ra = 4'd2;
    step();
    check("sweep ignored write addr2", {24'd0, dout}, 0);

    // clear_start together with a write to addr 0
    fill16(8'h80);
    cs = 1'b1; we = 1'b1; wa = 4'd0; din = 8'h77; ra = 4'd0;
    step();
    cs = 1'b0; we = 1'b0;
    check("cs+wr busy", {31'd0, busy}, 1);
    ra = 4'd6;
    run_sweep("cs+wr", 16, 1'b1);
    for (int i = 0; i < 16; i++) m16[i] = 8'h00;
    read_all16("cs+wr");

    // Reset in the middle of a sweep restarts from address 0
    fill16(8'h40);
    cs = 1'b1;
    step();
    cs = 1'b0;
    for (int i = 0; i < 7; i++) step();
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    check("mid-reset busy", {31'd0, busy}, 1);
    check("mid-reset clear_done", {31'd0, cdone}, 0);
    rst_n = 1'b1;
    run_sweep("mid-reset", 16, 1'b1);
    for (int i = 0; i < 16; i++) m16[i] = 8'h00;
    read_all16("mid-reset");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/memory_array.md
# memory_array

Parametrised single-clock memory with one synchronous write port, one read port and a built-in hardware clear sequencer. It is the generalised successor of the 1-bit, 2-location memory cell: configurable word width and depth, out-of-range protection, and a state machine that initialises every location to a known value after reset or on request. It serves as local state storage for pneumatic-logic sequencing blocks.

## Interface
- DATA_WIDTH, 8: word width in bits (≥1)
- DEPTH, 16: number of words (≥2, need not be a power of two)
- ADDR_WIDTH, $clog2(DEPTH): address width; derived, never overridden
- CLEAR_VALUE, {DATA_WIDTH{1'b0}}: value written to every word by the clear sequencer
- clk  input  1  single clock, rising-edge active
- rst_n  input  1  asynchronous, active-low reset
- write_enable  input  1  write request, sampled on clk rising edge
- write_address  input  ADDR_WIDTH  write location
- data_in  input  DATA_WIDTH  write data
- read_address  input  ADDR_WIDTH  read location
- data_out  output  DATA_WIDTH  read data
- clear_start  input  1  request a full clear, sampled on clk rising edge
- busy  output  1  clear sequencer active; user writes are ignored
- clear_done  output  1  one-cycle pulse when a clear sweep completes

## Operation
- FSM states: CLEAR, DONE, IDLE. A clear pointer of ADDR_WIDTH bits is used only in CLEAR.
- Reset (rst_n low, asynchronous): state=CLEAR, pointer=0, busy=1, clear_done=0. Memory contents are not reset directly; the sweep initialises them.
- CLEAR: each cycle writes CLEAR_VALUE to mem[pointer] and increments pointer; at pointer==DEPTH-1 the write completes and the FSM goes to DONE. write_enable and clear_start are ignored.
- DONE: clear_done=1, busy=0 for exactly one cycle; user writes are accepted; then IDLE.
- IDLE: write_enable=1 writes data_in to mem[write_address] on the edge. clear_start=1 moves the FSM to CLEAR with pointer=0. If write_enable and clear_start are both high, the write is performed and the sweep overwrites it later.
- Out-of-range addresses (≥DEPTH): writes are dropped and reads return all zeros.
- Read (default, combinational): data_out = mem[read_address]. While busy=1, data_out = CLEAR_VALUE regardless of address.
- Reset mid-sweep restarts the sweep from pointer 0.

## Timing
- The sweep lasts DEPTH cycles with busy high: first edge after rst_n rises (or after clear_start is sampled) clears address 0; the DEPTH-th edge clears address DEPTH-1.
- clear_done is high in the cycle after the last clear edge; busy falls in that same cycle.
- Write latency: new data is visible on data_out (combinational mode) immediately after the write edge when read_address matches.
- clear_start to busy high: 1 edge. Total clear_start to clear_done: DEPTH+1 edges.

## Configuration
- MEMORY_READ_REG_EN defined: data_out is registered, with 1-cycle read latency and reset value 0. A write and a read to the same in-range address in the same cycle are write-first: data_out shows data_in after the edge. While busy, the register loads CLEAR_VALUE.
- MEMORY_READ_REG_EN undefined: combinational read as described under Operation; no read register.

## Test plan
- Release reset with DEPTH=16 -> busy=1 for 16 cycles, clear_done pulses on cycle 17, then all 16 reads return 0x00.
- In IDLE, write 0xA5 to addr 3 and 0x5A to addr 15 -> reading addr 3 gives 0xA5 and addr 15 gives 0x5A; other addresses stay 0x00.
- With DEPTH=10, write 0xFF to addr 12 -> no location changes, and reading addr 12 gives 0x00.
- Assert write_enable (addr 2, 0x11) during the sweep -> the write is ignored and addr 2 reads CLEAR_VALUE after clear_done.
- After filling memory, pulse clear_start together with a write to addr 0 -> busy for 16 cycles and all words read CLEAR_VALUE. Assert rst_n low at pointer 7 -> the sweep restarts at 0 and clear_done comes 17 cycles after release.
- MEMORY_READ_REG_EN: write 0x3C to addr 4 while read_address=4 -> data_out=0x3C after that edge. A read of addr 4 issued the next cycle appears one cycle later.
